// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants for the NES-style bus blocks.
// Register addresses, bus direction and the sprite-DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] REG_OAMDMA  = 16'h4014;
  localparam logic [15:0] REG_OAMDATA = 16'h2004;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: snoops $4014 writes, stalls the CPU and copies one
// page into OAMDATA as alternating read/write bus cycles.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = REG_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = REG_OAMDATA,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_r_nw,
  input  logic [7:0]  bus_data_in,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_out,
  output logic        dma_r_nw,
  output logic [8:0]  busy_cnt_dbg
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
  localparam logic [8:0] LEN9     = 9'(XFER_LEN);

  logic [2:0]  r_state;
  logic        r_cyc_odd;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic        r_rdy;
  logic        r_active;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic        r_r_nw;
  logic [8:0]  r_cnt;

  logic        w_trig;
  logic [7:0]  w_idx_nxt;

  assign w_trig    = (cpu_addr == DMA_REG_ADDR) &&
                     (cpu_r_nw == BUS_WRITE);
  assign w_idx_nxt = r_idx + 8'd1;

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cyc_odd <= 1'b0;
      r_page    <= 8'h00;
      r_idx     <= 8'h00;
      r_rdy     <= 1'b1;
      r_active  <= 1'b0;
      r_addr    <= 16'h0000;
      r_data    <= 8'h00;
      r_r_nw    <= BUS_READ;
      r_cnt     <= 9'd0;
    end else begin
      r_cyc_odd <= ~r_cyc_odd;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state  <= S_HALT;
            r_page   <= cpu_data_out;
            r_idx    <= 8'h00;
            r_rdy    <= 1'b0;
            r_active <= 1'b1;
            r_r_nw   <= BUS_READ;
            r_addr   <= cpu_addr;
            r_cnt    <= LEN9;
          end
        end
        S_HALT: begin
          // next cycle would be odd: burn one more so READs land even
          if (!r_cyc_odd) begin
            r_state <= S_ALIGN;
          end else begin
            r_state <= S_READ;
            r_addr  <= {r_page, r_idx};
          end
        end
        S_ALIGN: begin
          r_state <= S_READ;
          r_addr  <= {r_page, r_idx};
        end
        S_READ: begin
          r_state <= S_WRITE;
          r_data  <= bus_data_in;
          r_addr  <= OAM_DATA_ADDR;
          r_r_nw  <= BUS_WRITE;
        end
        S_WRITE: begin
          r_idx  <= w_idx_nxt;
          r_r_nw <= BUS_READ;
          if (r_idx == LAST_IDX) begin
            r_state  <= S_DONE;
            r_active <= 1'b0;
            r_rdy    <= 1'b1;
            r_addr   <= 16'h0000;
            r_cnt    <= 9'd0;
          end else begin
            r_state <= S_READ;
            r_addr  <= {r_page, w_idx_nxt};
            r_cnt   <= LEN9 - {1'b0, w_idx_nxt};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_rdy    <= 1'b1;
          r_active <= 1'b0;
          r_r_nw   <= BUS_READ;
          r_cnt    <= 9'd0;
        end
      endcase
    end
  end

  assign rdy          = r_rdy;
  assign dma_active   = r_active;
  assign dma_addr     = r_addr;
  assign dma_data_out = r_data;
  assign dma_r_nw     = r_r_nw;
  assign busy_cnt_dbg = r_cnt;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: idle vectors from a table, then
// full transfers with per-cycle bus checks.
module tb_oam_dma;

  logic        clk_ph1 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_out = 8'h00;
  logic        cpu_r_nw = 1'b1;
  logic [7:0]  bus_data_in;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out;
  logic        dma_r_nw;
  logic [8:0]  busy_cnt_dbg;

  oam_dma dut (
    .clk_ph1      (clk_ph1),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_r_nw     (cpu_r_nw),
    .bus_data_in  (bus_data_in),
    .rdy          (rdy),
    .dma_active   (dma_active),
    .dma_addr     (dma_addr),
    .dma_data_out (dma_data_out),
    .dma_r_nw     (dma_r_nw),
    .busy_cnt_dbg (busy_cnt_dbg)
  );

  always #5 clk_ph1 = ~clk_ph1;

  // memory model: each byte is its low address bits xor $A5
  assign bus_data_in = dma_addr[7:0] ^ 8'hA5;

  bit m_odd;
  always @(posedge clk_ph1 or posedge rst)
    if (rst) m_odd <= 1'b0;
    else     m_odd <= ~m_odd;

  int errors = 0;
  int checks = 0;

  // {rdy, active, r_nw, addr[15:0], data[7:0], cnt[8:0]}
  localparam logic [35:0] M_CTL = {3'b111, 16'h0, 8'h0, 9'h1FF};
  localparam logic [35:0] M_ADR = {3'b111, 16'hFFFF, 8'h0, 9'h1FF};
  localparam logic [35:0] M_ALL = '1;

  wire [35:0] w_obs = {rdy, dma_active, dma_r_nw, dma_addr,
                       dma_data_out, busy_cnt_dbg};

  function automatic logic [35:0] pk(
    input logic r, input logic a, input logic w,
    input logic [15:0] ad, input logic [7:0] d, input logic [8:0] c);
    return {r, a, w, ad, d, c};
  endfunction

  task automatic chk(input string nm, input logic [35:0] m,
                     input logic [35:0] e);
    checks++;
    if ((w_obs & m) !== (e & m)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mask %h) t=%0t",
               nm, w_obs & m, e & m, m, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d,
                       input logic w);
    cpu_addr     = a;
    cpu_data_out = d;
    cpu_r_nw     = w;
  endtask

  typedef struct {
    logic        r;
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic [35:0] m;
    logic [35:0] e;
  } vec_t;

  vec_t vecs[7];

  // par: 0/1 = trigger on that parity, 2 = trigger immediately
  task automatic do_xfer(input logic [7:0] pg, input int par,
                         input int rst_at, input int wr_at);
    int  low;
    bit  odd_trig;
    drive(16'h0000, 8'h00, 1'b1);
    for (int k = 0; k < 2 && par < 2 && m_odd != par[0]; k++) tick;
    odd_trig = m_odd;
    drive(16'h4014, pg, 1'b0);
    tick;
    drive(16'h0000, 8'h00, 1'b1);
    low = 0;
    chk("halt", M_ADR, pk(1'b0, 1'b1, 1'b1, 16'h4014, 8'h00, 9'd256));
    if (!rdy) low++;
    if (odd_trig) begin
      tick;
      chk("align", M_CTL, pk(1'b0, 1'b1, 1'b1, 16'h0, 8'h00, 9'd256));
      if (!rdy) low++;
    end
    for (int b = 0; b < 256; b++) begin
      tick;
      chk("read", M_ADR,
          pk(1'b0, 1'b1, 1'b1, {pg, 8'(b)}, 8'h00, 9'(256 - b)));
      if (!rdy) low++;
      if (b == wr_at) drive(16'h4014, 8'h03, 1'b0);
      tick;
      drive(16'h0000, 8'h00, 1'b1);
      chk("write", M_ALL,
          pk(1'b0, 1'b1, 1'b0, 16'h2004, 8'(b) ^ 8'hA5, 9'(256 - b)));
      if (!rdy) low++;
      if (b == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_mid", M_CTL, pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0));
        tick;
        rst = 1'b0;
        drive(16'h4014, 8'h09, 1'b1);
        tick;
        chk("rd4014_after_rst", M_CTL,
            pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0));
        drive(16'h0000, 8'h00, 1'b1);
        tick;
        chk("idle_after_rst", M_CTL,
            pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0));
        return;
      end
    end
    tick;
    chk("done", M_CTL, pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0));
    checks++;
    if (low != 513 + int'(odd_trig)) begin
      errors++;
      $display("FAIL stall_len: rdy low %0d cycles, expected %0d",
               low, 513 + int'(odd_trig));
    end
    tick;
    chk("idle", M_CTL, pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0));
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h0000, 8'h00, 1'b1, M_ALL,
                pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0)};
    vecs[1] = '{1'b0, 16'h4014, 8'h02, 1'b1, M_CTL,
                pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0)};
    vecs[2] = '{1'b0, 16'h4015, 8'h02, 1'b0, M_CTL,
                pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0)};
    vecs[3] = '{1'b0, 16'h4013, 8'h02, 1'b0, M_CTL,
                pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0)};
    vecs[4] = '{1'b0, 16'h0014, 8'h02, 1'b0, M_CTL,
                pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0)};
    vecs[5] = '{1'b0, 16'h2004, 8'h02, 1'b0, M_CTL,
                pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0)};
    vecs[6] = '{1'b0, 16'h4014, 8'hFF, 1'b1, M_CTL,
                pk(1'b1, 1'b0, 1'b1, 16'h0, 8'h0, 9'd0)};

    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].r;
      drive(vecs[i].a, vecs[i].d, vecs[i].w);
      tick;
      chk($sformatf("vec%0d", i), vecs[i].m, vecs[i].e);
    end

    do_xfer(8'h02, 0, -1, -1);
    do_xfer(8'h02, 1, -1, -1);
    do_xfer(8'hFF, 0, -1, -1);
    do_xfer(8'h02, 1, -1, 100);
    do_xfer(8'h02, 2, -1, -1);
    do_xfer(8'h02, 2, 37, -1);
    do_xfer(8'h05, 2, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
